// File: rtl/eth_frame_pkg.sv
// Shared types and header layout for the Ethernet frame packer.
package eth_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } rd_state_e;

  localparam int SEQ_LSB = 16;
  localparam int LEN_LSB = 0;
  localparam int SEQ_W   = 16;
  localparam int LEN_W   = 16;

  function automatic logic [31:0] make_header(input logic [SEQ_W-1:0] seq,
                                              input logic [LEN_W-1:0] len);
    logic [31:0] hdr;
    hdr = 32'd0;
    hdr[SEQ_LSB +: SEQ_W] = seq;
    hdr[LEN_LSB +: LEN_W] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/eth_sync_fifo.sv
// Single-clock LUT FIFO with asynchronous read; full/empty come from a registered count.
module eth_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO_C = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_ONE_C  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push_s;
  logic             pop_s;

  assign o_full  = (cnt_q == CNT_FULL_C);
  assign o_empty = (cnt_q == CNT_ZERO_C);
  assign push_s  = i_push && !o_full;
  assign pop_s   = i_pop && !o_empty;
  assign o_data  = mem_q[rd_ptr_q];

  // storage array, no reset so it maps onto distributed RAM
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= CNT_ZERO_C;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE_C;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE_C;
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_ONE_C;
        2'b01:   cnt_q <= cnt_q - CNT_ONE_C;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/eth_frame_packer.sv
// Buffers a valid-only word stream, cuts it into length-prefixed frames (full or
// idle-timeout flushed) and emits header + payload on a valid/ready stream.
module eth_frame_packer
  import eth_frame_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int FRAME_WORDS   = 256,
  parameter int BUF_DEPTH     = 1024,
  parameter int LEN_DEPTH     = 16,
  parameter int FLUSH_TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_clk_rst,
  input  logic             i_data_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_vld,
  output logic             o_data_sop,
  output logic             o_data_eop,
  input  logic             i_data_rdy,
  output logic [15:0]      o_drop_cnt
);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [LEN_W-1:0] FRAME_LEN_C = LEN_W'(FRAME_WORDS);
  localparam logic [TW-1:0]    TIMEOUT_C   = TW'(FLUSH_TIMEOUT);
  localparam logic [TW-1:0]    TMR_ONE_C   = TW'(1);
  localparam logic [TW-1:0]    TMR_ZERO_C  = TW'(0);

  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d, pend_len_q, pend_len_d, rd_cnt_q, rd_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             pend_q, pend_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  rd_state_e        state_q, state_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             o_vld_q, o_vld_d, o_sop_q, o_sop_d, o_eop_q, o_eop_d;

  logic             buf_full_s, buf_empty_s, buf_pop_s, accept_s, hs_s;
  logic [WIDTH-1:0] buf_head_s;
  logic             len_full_s, len_empty_s, len_push_s, len_pop_s;
  logic [LEN_W-1:0] len_push_data_s, len_head_s, wr_cnt_inc_s;
  logic             full_commit_s, timeout_s;

  eth_sync_fifo #(.WIDTH(WIDTH), .DEPTH(BUF_DEPTH)) u_data_buf (
    .i_clk(i_clk), .i_rst(i_clk_rst), .i_push(accept_s), .i_data(i_data),
    .i_pop(buf_pop_s), .o_data(buf_head_s), .o_full(buf_full_s), .o_empty(buf_empty_s)
  );

  eth_sync_fifo #(.WIDTH(LEN_W), .DEPTH(LEN_DEPTH)) u_len_q (
    .i_clk(i_clk), .i_rst(i_clk_rst), .i_push(len_push_s), .i_data(len_push_data_s),
    .i_pop(len_pop_s), .o_data(len_head_s), .o_full(len_full_s), .o_empty(len_empty_s)
  );

  // A pending (failed) commit closes the frame, so words are dropped until it lands.
  assign accept_s      = i_data_vld && !buf_full_s && !pend_q;
  assign wr_cnt_inc_s  = wr_cnt_q + 16'd1;
  assign full_commit_s = accept_s && (wr_cnt_inc_s == FRAME_LEN_C);
  assign timeout_s     = !i_data_vld && (wr_cnt_q != 16'd0) && ((timer_q + TMR_ONE_C) == TIMEOUT_C);
  assign hs_s          = o_vld_q && i_data_rdy;

  // write side: frame counting, commits, idle timer, drop counter
  always_comb begin
    wr_cnt_d        = wr_cnt_q;
    pend_d          = pend_q;
    pend_len_d      = pend_len_q;
    len_push_s      = 1'b0;
    len_push_data_s = pend_len_q;
    if (pend_q) begin
      if (!len_full_s) begin
        len_push_s = 1'b1;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (full_commit_s || timeout_s) begin
      len_push_data_s = full_commit_s ? FRAME_LEN_C : wr_cnt_q;
      wr_cnt_d        = 16'd0;
      if (!len_full_s) begin
        len_push_s = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_len_d = len_push_data_s;
      end
    end else if (accept_s) begin
      wr_cnt_d = wr_cnt_inc_s;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    if (i_data_vld || timeout_s || (wr_cnt_q == 16'd0)) begin
      timer_d = TMR_ZERO_C;
    end else begin
      timer_d = timer_q + TMR_ONE_C;
    end

    if (i_data_vld && !accept_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // read FSM: header, then payload prefetched from the buffer on every handshake
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    seq_d     = seq_q;
    o_data_d  = o_data_q;
    o_vld_d   = o_vld_q;
    o_sop_d   = o_sop_q;
    o_eop_d   = o_eop_q;
    buf_pop_s = 1'b0;
    len_pop_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!len_empty_s && !buf_empty_s) begin
          state_d  = HDR;
          o_data_d = WIDTH'(make_header(seq_q, len_head_s));
          o_vld_d  = 1'b1;
          o_sop_d  = 1'b1;
          o_eop_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (hs_s) begin
          state_d   = PAY;
          buf_pop_s = 1'b1;
          o_data_d  = buf_head_s;
          o_sop_d   = 1'b0;
          rd_cnt_d  = 16'd0;
          o_eop_d   = (len_head_s == 16'd1);
        end else begin
          state_d = HDR;
        end
      end
      PAY: begin
        if (hs_s && o_eop_q) begin
          state_d   = IDLE;
          len_pop_s = 1'b1;
          seq_d     = seq_q + 16'd1;
          o_data_d  = {WIDTH{1'b0}};
          o_vld_d   = 1'b0;
          o_eop_d   = 1'b0;
        end else if (hs_s) begin
          buf_pop_s = 1'b1;
          o_data_d  = buf_head_s;
          rd_cnt_d  = rd_cnt_q + 16'd1;
          o_eop_d   = (rd_cnt_d == (len_head_s - 16'd1));
        end else begin
          state_d = PAY;
        end
      end
      default: begin
        state_d  = IDLE;
        o_data_d = {WIDTH{1'b0}};
        o_vld_d  = 1'b0;
        o_sop_d  = 1'b0;
        o_eop_d  = 1'b0;
      end
    endcase
  end

  // state registers
  always_ff @(posedge i_clk) begin
    if (i_clk_rst) begin
      wr_cnt_q   <= 16'd0;
      pend_q     <= 1'b0;
      pend_len_q <= 16'd0;
      timer_q    <= TMR_ZERO_C;
      drop_cnt_q <= 16'd0;
      state_q    <= IDLE;
      rd_cnt_q   <= 16'd0;
      seq_q      <= 16'd0;
      o_data_q   <= {WIDTH{1'b0}};
      o_vld_q    <= 1'b0;
      o_sop_q    <= 1'b0;
      o_eop_q    <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      timer_q    <= timer_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      seq_q      <= seq_d;
      o_data_q   <= o_data_d;
      o_vld_q    <= o_vld_d;
      o_sop_q    <= o_sop_d;
      o_eop_q    <= o_eop_d;
    end
  end

  assign o_data     = o_data_q;
  assign o_data_vld = o_vld_q;
  assign o_data_sop = o_sop_q;
  assign o_data_eop = o_eop_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_frame_packer.sv
// Directed bench for eth_frame_packer with small frame, buffer and timeout sizes.
module tb_eth_frame_packer;

  logic        clk = 1'b0;
  logic        i_clk_rst = 1'b1;
  logic        i_data_vld = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        i_data_rdy = 1'b0;
  logic [31:0] o_data;
  logic        o_data_vld, o_data_sop, o_data_eop;
  logic [15:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [33:0] rec_q[$];
  int          rec_cyc_q[$];
  logic        snap_vld, snap_sop, snap_eop;
  logic [31:0] snap_data;

  always #5 clk = ~clk;

  eth_frame_packer #(
    .WIDTH(32), .FRAME_WORDS(4), .BUF_DEPTH(8), .LEN_DEPTH(4), .FLUSH_TIMEOUT(8)
  ) dut (
    .i_clk(clk), .i_clk_rst(i_clk_rst), .i_data_vld(i_data_vld), .i_data(i_data),
    .o_data(o_data), .o_data_vld(o_data_vld), .o_data_sop(o_data_sop),
    .o_data_eop(o_data_eop), .i_data_rdy(i_data_rdy), .o_drop_cnt(o_drop_cnt)
  );

  // One clock: snapshot outputs, log the handshake the new rdy will cause, drive inputs.
  task automatic cycle(input logic rst, input logic vld, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    cyc++;
    snap_vld  = o_data_vld;
    snap_sop  = o_data_sop;
    snap_eop  = o_data_eop;
    snap_data = o_data;
    if (o_data_vld && rdy && !rst) begin
      rec_q.push_back({o_data_sop, o_data_eop, o_data});
      rec_cyc_q.push_back(cyc);
    end
    i_clk_rst  = rst;
    i_data_vld = vld;
    i_data     = d;
    i_data_rdy = rdy;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    rec_q.delete();
    rec_cyc_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (snap_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b expected 0", snap_vld); end
    checks++; if (snap_sop !== 1'b0) begin errors++; $display("FAIL reset_sop got %b expected 0", snap_sop); end
    checks++; if (snap_eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b expected 0", snap_eop); end
    checks++; if (snap_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h expected 0", snap_data); end
    checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d expected 0", o_drop_cnt); end
  endtask

  task automatic test_single_frame();
    logic [33:0] exp_a [5];
    logic [33:0] got;
    int k, hdr_cyc, eop_cyc;
    exp_a = '{34'h2_0000_0004, 34'h0_0000_0001, 34'h0_0000_0002, 34'h0_0000_0003, 34'h1_0000_0004};
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 32'(i), 1'b1);
    k = cyc;
    repeat (10) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    checks++; if (rec_q.size() != 5) begin errors++; $display("FAIL single_count got %0d expected 5", rec_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rec_q.size()) ? rec_q[i] : 34'h3_FFFF_FFFF;
      checks++;
      if (got !== exp_a[i]) begin errors++; $display("FAIL single_word%0d got %h expected %h", i, got, exp_a[i]); end
    end
    hdr_cyc = (rec_cyc_q.size() > 0) ? rec_cyc_q[0] : -1;
    eop_cyc = (rec_cyc_q.size() > 4) ? rec_cyc_q[4] : -1;
    checks++; if (hdr_cyc != k + 2) begin errors++; $display("FAIL single_hdr_latency got %0d expected %0d", hdr_cyc, k + 2); end
    checks++; if (eop_cyc - hdr_cyc != 4) begin errors++; $display("FAIL single_throughput got %0d expected 4", eop_cyc - hdr_cyc); end
    checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL single_drop got %0d expected 0", o_drop_cnt); end
  endtask

  task automatic test_timeout();
    logic [33:0] exp_a [7];
    logic [33:0] got;
    exp_a = '{34'h2_0000_0003, 34'h0_0000_000A, 34'h0_0000_000B, 34'h1_0000_000C,
              34'h2_0001_0002, 34'h0_0000_0011, 34'h1_0000_0022};
    do_reset();
    cycle(1'b0, 1'b1, 32'h0000_000A, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_000B, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_000C, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      if (i == 9) begin
        checks++; if (snap_vld !== 1'b0) begin errors++; $display("FAIL timeout_early got vld=%b expected 0", snap_vld); end
      end
      if (i == 10) begin
        checks++;
        if ({snap_vld, snap_sop, snap_data} !== {1'b1, 1'b1, 32'h0000_0003}) begin
          errors++; $display("FAIL timeout_hdr got vld=%b sop=%b data=%h expected 1 1 00000003", snap_vld, snap_sop, snap_data);
        end
      end
    end
    repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0011, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0022, 1'b1);
    repeat (16) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    checks++; if (rec_q.size() != 7) begin errors++; $display("FAIL timeout_count got %0d expected 7", rec_q.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (i < rec_q.size()) ? rec_q[i] : 34'h3_FFFF_FFFF;
      checks++;
      if (got !== exp_a[i]) begin errors++; $display("FAIL timeout_word%0d got %h expected %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp_a [10];
    logic [33:0] got;
    logic [34:0] prev_s, cur_s;
    logic        rdy, prev_rdy;
    exp_a = '{34'h2_0000_0004, 34'h0_0000_0001, 34'h0_0000_0002, 34'h0_0000_0003, 34'h1_0000_0004,
              34'h2_0001_0004, 34'h0_0000_0005, 34'h0_0000_0006, 34'h0_0000_0007, 34'h1_0000_0008};
    do_reset();
    prev_rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rdy    = ((i % 2) == 0);
      prev_s = {snap_vld, snap_sop, snap_eop, snap_data};
      cycle(1'b0, (i < 8), 32'(i + 1), rdy);
      cur_s  = {snap_vld, snap_sop, snap_eop, snap_data};
      if (i > 0 && prev_s[34] && !prev_rdy) begin
        checks++;
        if (cur_s !== prev_s) begin errors++; $display("FAIL bp_hold cyc%0d got %h expected %h", i, cur_s, prev_s); end
      end
      prev_rdy = rdy;
    end
    checks++; if (rec_q.size() != 10) begin errors++; $display("FAIL bp_count got %0d expected 10", rec_q.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < rec_q.size()) ? rec_q[i] : 34'h3_FFFF_FFFF;
      checks++;
      if (got !== exp_a[i]) begin errors++; $display("FAIL bp_word%0d got %h expected %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [33:0] got;
    int pay_n, hdr_n;
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    checks++; if (o_drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop got %0d expected 4", o_drop_cnt); end
    repeat (30) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    pay_n = 0;
    hdr_n = 0;
    for (int i = 0; i < rec_q.size(); i++) begin
      got = rec_q[i];
      if (got[33]) begin
        hdr_n++;
      end else begin
        checks++;
        if (got[31:0] !== 32'h100 + 32'(pay_n)) begin errors++; $display("FAIL ovf_pay%0d got %h expected %h", pay_n, got[31:0], 32'h100 + 32'(pay_n)); end
        pay_n++;
      end
    end
    checks++; if (pay_n != 8) begin errors++; $display("FAIL ovf_pay_count got %0d expected 8", pay_n); end
    checks++; if (hdr_n != 2) begin errors++; $display("FAIL ovf_hdr_count got %0d expected 2", hdr_n); end
  endtask

  task automatic test_reset_mid_frame();
    logic [33:0] got;
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 32'h40 + 32'(i), 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 32'h50 + 32'(i), 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    checks++; if ({snap_vld, snap_sop} !== 2'b10) begin errors++; $display("FAIL mid_in_pay got vld=%b sop=%b expected 1 0", snap_vld, snap_sop); end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if ({snap_vld, snap_sop, snap_eop, snap_data} !== 35'd0) begin
      errors++; $display("FAIL mid_outputs got vld=%b sop=%b eop=%b data=%h expected all 0", snap_vld, snap_sop, snap_eop, snap_data);
    end
    rec_q.delete();
    rec_cyc_q.delete();
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 32'h60 + 32'(i), 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    got = (rec_q.size() > 0) ? rec_q[0] : 34'h3_FFFF_FFFF;
    checks++; if (got !== 34'h2_0000_0004) begin errors++; $display("FAIL mid_hdr_seq got %h expected 200000004", got); end
    got = (rec_q.size() > 1) ? rec_q[1] : 34'h3_FFFF_FFFF;
    checks++; if (got !== 34'h0_0000_0061) begin errors++; $display("FAIL mid_first_pay got %h expected 000000061", got); end
    checks++; if (rec_q.size() != 5) begin errors++; $display("FAIL mid_count got %0d expected 5", rec_q.size()); end
  endtask

  task automatic test_seq_wrap();
    logic [33:0] got;
    do_reset();
    force dut.seq_q = 16'hFFFF;
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    release dut.seq_q;
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 32'h70 + 32'(i), 1'b1);
    repeat (20) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    checks++; if (rec_q.size() != 10) begin errors++; $display("FAIL wrap_count got %0d expected 10", rec_q.size()); end
    got = (rec_q.size() > 0) ? rec_q[0] : 34'h3_FFFF_FFFF;
    checks++; if (got !== 34'h2_FFFF_0004) begin errors++; $display("FAIL wrap_hdr0 got %h expected 2ffff0004", got); end
    got = (rec_q.size() > 5) ? rec_q[5] : 34'h3_FFFF_FFFF;
    checks++; if (got !== 34'h2_0000_0004) begin errors++; $display("FAIL wrap_hdr1 got %h expected 200000004", got); end
    got = (rec_q.size() > 9) ? rec_q[9] : 34'h3_FFFF_FFFF;
    checks++; if (got !== 34'h1_0000_0078) begin errors++; $display("FAIL wrap_last got %h expected 100000078", got); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_timeout();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
